roce_tx_opcode_sequencer: RTL and testbench

Sits directly downstream of the TX packet framer in the RoCEv2 TX engine. Takes one DMA write request and the PMTU-sized payload packets the framer produces, whose `tuser` carries length, last-in-transfer and bad-frame bits. For each packet it emits one BTH/RETH/ImmDt header descriptor and then passes that packet's payload through. It assigns opcodes (FIRST/MIDDLE/LAST/ONLY, with or without immediate) and 24-bit PSNs.

---
 rtl/roce_tx_opcode_sequencer_if.sv | 68 ++++++
 rtl/roce_tx_opcode_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_roce_tx_opcode_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/roce_tx_opcode_sequencer_if.sv
// Handshake bundle for the RoCEv2 TX opcode sequencer: write request, framed
// payload in, header descriptor out and payload out.
interface roce_tx_opcode_sequencer_if #(
    parameter int DATA_WIDTH = 64
);
    logic                    s_wr_req_valid;
    logic                    s_wr_req_ready;
    logic [23:0]             s_wr_req_loc_qp;
    logic [31:0]             s_wr_req_dma_length;
    logic [63:0]             s_wr_req_addr_offset;
    logic                    s_wr_req_is_immediate;
    logic [31:0]             s_wr_req_immediate_data;
    logic                    s_wr_req_tx_type;

    logic [DATA_WIDTH-1:0]   s_axis_tdata;
    logic [DATA_WIDTH/8-1:0] s_axis_tkeep;
    logic                    s_axis_tvalid;
    logic                    s_axis_tready;
    logic                    s_axis_tlast;
    logic [14:0]             s_axis_tuser;

    logic                    m_hdr_valid;
    logic                    m_hdr_ready;
    logic [7:0]              m_hdr_opcode;
    logic [23:0]             m_hdr_psn;
    logic [23:0]             m_hdr_dest_qp;
    logic                    m_hdr_ack_req;
    logic                    m_hdr_reth_present;
    logic [63:0]             m_hdr_reth_addr;
    logic [31:0]             m_hdr_reth_length;
    logic                    m_hdr_immdt_present;
    logic [31:0]             m_hdr_immdt;
    logic [12:0]             m_hdr_payload_length;
    logic                    m_hdr_bad;

    logic [DATA_WIDTH-1:0]   m_axis_tdata;
    logic [DATA_WIDTH/8-1:0] m_axis_tkeep;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic                    m_axis_tlast;
    logic                    m_axis_tuser;

    // Environment side: issues requests and payload, consumes headers and payload.
    modport master (
        output s_wr_req_valid, s_wr_req_loc_qp, s_wr_req_dma_length, s_wr_req_addr_offset,
               s_wr_req_is_immediate, s_wr_req_immediate_data, s_wr_req_tx_type,
               s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
               m_hdr_ready, m_axis_tready,
        input  s_wr_req_ready, s_axis_tready,
               m_hdr_valid, m_hdr_opcode, m_hdr_psn, m_hdr_dest_qp, m_hdr_ack_req,
               m_hdr_reth_present, m_hdr_reth_addr, m_hdr_reth_length,
               m_hdr_immdt_present, m_hdr_immdt, m_hdr_payload_length, m_hdr_bad,
               m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    // Sequencer side.
    modport slave (
        input  s_wr_req_valid, s_wr_req_loc_qp, s_wr_req_dma_length, s_wr_req_addr_offset,
               s_wr_req_is_immediate, s_wr_req_immediate_data, s_wr_req_tx_type,
               s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
               m_hdr_ready, m_axis_tready,
        output s_wr_req_ready, s_axis_tready,
               m_hdr_valid, m_hdr_opcode, m_hdr_psn, m_hdr_dest_qp, m_hdr_ack_req,
               m_hdr_reth_present, m_hdr_reth_addr, m_hdr_reth_length,
               m_hdr_immdt_present, m_hdr_immdt, m_hdr_payload_length, m_hdr_bad,
               m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/roce_tx_opcode_sequencer.sv
// RoCEv2 TX opcode sequencer: one BTH/RETH/ImmDt descriptor per framed packet, then payload passthrough.
// Optional transfer length check enabled by defining ROCE_TX_SEQ_LEN_CHECK_EN.
module roce_tx_opcode_sequencer (
    input  logic                              clk,
    input  logic                              rst_n,
    roce_tx_opcode_sequencer_if.slave         bus,
    input  logic                              cfg_psn_load,
    input  logic [23:0]                       cfg_psn_value,
    output logic                              err_len_mismatch
);
    typedef enum logic [1:0] {IDLE, HDR, HDR_WAIT, PAYLOAD} state_t;

    typedef struct packed {
        logic [23:0] loc_qp;
        logic [31:0] dma_length;
        logic [63:0] addr_offset;
        logic        is_immediate;
        logic [31:0] immediate_data;
        logic        is_send;
    } req_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [23:0] psn;
        logic [23:0] dest_qp;
        logic        ack_req;
        logic        reth_present;
        logic [63:0] reth_addr;
        logic [31:0] reth_length;
        logic        immdt_present;
        logic [31:0] immdt;
        logic [12:0] payload_length;
        logic        bad;
    } hdr_t;

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    hdr_t        hdr_q, hdr_d;
    logic        hdr_valid_q, hdr_valid_d;
    logic        ready_q, ready_d;
    logic        first_q, first_d;
    logic        last_q, last_d;
    logic [23:0] psn_q, psn_d;
    logic        req_fire;
    logic        hdr_fire;
    logic        pkt_last;

    // Opcodes are laid out as FIRST, MIDDLE, LAST, LAST_IMM, ONLY, ONLY_IMM from a per-type base.
    function automatic logic [7:0] opcode_f(input logic is_send, input logic imm,
                                            input logic first, input logic last);
        logic [7:0] base;
        base = is_send ? 8'h00 : 8'h06;
        if (first && !last)
            return base;
        else if (!last)
            return base + 8'd1;
        else if (!first)
            return base + 8'd2 + {7'd0, imm};
        else
            return base + 8'd4 + {7'd0, imm};
    endfunction

    assign req_fire = (state_q == IDLE) && ready_q && bus.s_wr_req_valid;
    assign hdr_fire = hdr_valid_q && bus.m_hdr_ready;
    assign pkt_last = bus.s_axis_tuser[1];

    always_comb begin
        state_d           = state_q;
        req_d             = req_q;
        hdr_d             = hdr_q;
        hdr_valid_d       = hdr_valid_q;
        first_d           = first_q;
        last_d            = last_q;
        psn_d             = psn_q;
        bus.s_axis_tready = 1'b0;
        bus.m_axis_tvalid = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    req_d.loc_qp         = bus.s_wr_req_loc_qp;
                    req_d.dma_length     = bus.s_wr_req_dma_length;
                    req_d.addr_offset    = bus.s_wr_req_addr_offset;
                    req_d.is_immediate   = bus.s_wr_req_is_immediate;
                    req_d.immediate_data = bus.s_wr_req_immediate_data;
                    req_d.is_send        = bus.s_wr_req_tx_type;
                    first_d              = 1'b1;
                    state_d              = HDR;
                end
            end
            HDR: begin
                // The first beat is only peeked here; it is consumed later in PAYLOAD.
                if (bus.s_axis_tvalid && !hdr_valid_q) begin
                    hdr_d.opcode         = opcode_f(req_q.is_send, req_q.is_immediate, first_q, pkt_last);
                    hdr_d.psn            = psn_q;
                    hdr_d.dest_qp        = req_q.loc_qp;
                    hdr_d.ack_req        = pkt_last;
                    hdr_d.reth_present   = !req_q.is_send && first_q;
                    hdr_d.reth_addr      = (!req_q.is_send && first_q) ? req_q.addr_offset : 64'd0;
                    hdr_d.reth_length    = (!req_q.is_send && first_q) ? req_q.dma_length : 32'd0;
                    hdr_d.immdt_present  = pkt_last && req_q.is_immediate;
                    hdr_d.immdt          = (pkt_last && req_q.is_immediate) ? req_q.immediate_data : 32'd0;
                    hdr_d.payload_length = bus.s_axis_tuser[14:2];
                    hdr_d.bad            = bus.s_axis_tuser[0];
                    last_d               = pkt_last;
                    hdr_valid_d          = 1'b1;
                    state_d              = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                if (hdr_fire) begin
                    hdr_valid_d = 1'b0;
                    psn_d       = psn_q + 24'd1;
                    first_d     = 1'b0;
                    state_d     = PAYLOAD;
                end
            end
            PAYLOAD: begin
                bus.s_axis_tready = bus.m_axis_tready;
                bus.m_axis_tvalid = bus.s_axis_tvalid;
                if (bus.s_axis_tvalid && bus.m_axis_tready && bus.s_axis_tlast)
                    state_d = last_q ? IDLE : HDR;
            end
            default: state_d = IDLE;
        endcase
        if (cfg_psn_load)
            psn_d = cfg_psn_value;
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            psn_q       <= 24'd0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            ready_q     <= ready_d;
            first_q     <= first_d;
            last_q      <= last_d;
            psn_q       <= psn_d;
        end
    end

    assign bus.s_wr_req_ready       = ready_q;
    assign bus.m_hdr_valid          = hdr_valid_q;
    assign bus.m_hdr_opcode         = hdr_q.opcode;
    assign bus.m_hdr_psn            = hdr_q.psn;
    assign bus.m_hdr_dest_qp        = hdr_q.dest_qp;
    assign bus.m_hdr_ack_req        = hdr_q.ack_req;
    assign bus.m_hdr_reth_present   = hdr_q.reth_present;
    assign bus.m_hdr_reth_addr      = hdr_q.reth_addr;
    assign bus.m_hdr_reth_length    = hdr_q.reth_length;
    assign bus.m_hdr_immdt_present  = hdr_q.immdt_present;
    assign bus.m_hdr_immdt          = hdr_q.immdt;
    assign bus.m_hdr_payload_length = hdr_q.payload_length;
    assign bus.m_hdr_bad            = hdr_q.bad;

    assign bus.m_axis_tdata = bus.s_axis_tdata;
    assign bus.m_axis_tkeep = bus.s_axis_tkeep;
    assign bus.m_axis_tlast = (state_q == PAYLOAD) && bus.s_axis_tlast;
    assign bus.m_axis_tuser = (state_q == PAYLOAD) && bus.s_axis_tuser[0];

`ifdef ROCE_TX_SEQ_LEN_CHECK_EN
    logic [31:0] len_acc_q, len_acc_d;
    logic        err_q, err_d;

    // The running sum includes the packet being accepted, so the last compare sees the full transfer.
    always_comb begin
        len_acc_d = len_acc_q;
        err_d     = 1'b0;
        if (req_fire) begin
            len_acc_d = 32'd0;
        end else if (hdr_fire) begin
            len_acc_d = len_acc_q + {19'd0, hdr_q.payload_length};
            err_d     = last_q && (len_acc_d != req_q.dma_length);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_acc_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            len_acc_q <= len_acc_d;
            err_q     <= err_d;
        end
    end

    assign err_len_mismatch = err_q;
`else
    assign err_len_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_roce_tx_opcode_sequencer.sv
// Randomized self-checking bench for roce_tx_opcode_sequencer against a transfer-level model.
module tb_roce_tx_opcode_sequencer;
    localparam int DW     = 64;
    localparam int BUDGET = 4000;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        bad;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfgPsnLoad = 1'b0;
    logic [23:0] cfgPsnValue = 24'd0;
    logic        errLenMismatch;

    int checkCount = 0;
    int errorCount = 0;
    int errPulses  = 0;

    // Current transfer description and model state
    bit          tSend, tImm;
    logic [31:0] tImmData, tDmaLen;
    logic [23:0] tQp;
    logic [63:0] tAddr;
    int          tNumPkts, tHold, tReadyMode;
    int          tLen [0:15];
    bit          tBad [0:15];
    logic [23:0] modelPsn = 24'd0;
    int          hdrAccepted;
    beat_t       expBeats [$];

    // Opcode per position: FIRST, MIDDLE, LAST, LAST_IMM, ONLY, ONLY_IMM; row 0 WRITE, row 1 SEND
    logic [7:0] opTable [0:1][0:5] = '{'{8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B},
                                       '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05}};

    roce_tx_opcode_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    roce_tx_opcode_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .cfg_psn_load     (cfgPsnLoad),
        .cfg_psn_value    (cfgPsnValue),
        .err_len_mismatch (errLenMismatch)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (errLenMismatch) errPulses++;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] expOpcode(input bit isSend, input bit imm, input bit first, input bit last);
        int pos;
        if (first && last)  pos = 4 + int'(imm);
        else if (first)     pos = 0;
        else if (last)      pos = 2 + int'(imm);
        else                pos = 1;
        return opTable[int'(isSend)][pos];
    endfunction

    task automatic setPsn(input logic [23:0] value);
        @(negedge clk);
        cfgPsnLoad  = 1'b1;
        cfgPsnValue = value;
        @(negedge clk);
        cfgPsnLoad  = 1'b0;
        modelPsn    = value;
    endtask

    task automatic setupTransfer(input bit isSend, input bit imm, input logic [31:0] immData,
                                 input int nPkts, input int hold, input int readyMode);
        tSend      = isSend;
        tImm       = imm;
        tImmData   = immData;
        tNumPkts   = nPkts;
        tHold      = hold;
        tReadyMode = readyMode;
        tQp        = 24'($urandom);
        tAddr      = {$urandom, $urandom};
        for (int i = 0; i < 16; i++) tBad[i] = 1'b0;
    endtask

    task automatic applyStimulus();
        int  waitCycles;
        bit  fire;
        waitCycles = 0;
        do begin
            @(negedge clk);
            bus.s_wr_req_valid          = 1'b1;
            bus.s_wr_req_loc_qp         = tQp;
            bus.s_wr_req_dma_length     = tDmaLen;
            bus.s_wr_req_addr_offset    = tAddr;
            bus.s_wr_req_is_immediate   = tImm;
            bus.s_wr_req_immediate_data = tImmData;
            bus.s_wr_req_tx_type        = tSend;
            #3;
            fire = bus.s_wr_req_ready;
            waitCycles++;
        end while (!fire && waitCycles < BUDGET);
        if (!fire) checkOutput("reqTimeout", 64'd0, 64'd1);
        @(negedge clk);
        bus.s_wr_req_valid = 1'b0;
        for (int p = 0; p < tNumPkts; p++) begin
            int nBeats;
            nBeats = (tLen[p] + 7) / 8;
            for (int b = 0; b < nBeats; b++) begin
                beat_t bt;
                int    rem;
                rem     = tLen[p] - b * 8;
                bt.data = {$urandom, $urandom};
                bt.keep = (rem >= 8) ? 8'hFF : (8'hFF >> (8 - rem));
                bt.last = (b == nBeats - 1);
                bt.bad  = tBad[p];
                expBeats.push_back(bt);
                if ($urandom_range(0, 3) == 0) begin
                    bus.s_axis_tvalid = 1'b0;
                    @(negedge clk);
                end
                bus.s_axis_tvalid = 1'b1;
                bus.s_axis_tdata  = bt.data;
                bus.s_axis_tkeep  = bt.keep;
                bus.s_axis_tlast  = bt.last;
                bus.s_axis_tuser  = {13'(tLen[p]), (p == tNumPkts - 1), tBad[p]};
                waitCycles = 0;
                #3;
                fire = bus.s_axis_tready;
                while (!fire && waitCycles < BUDGET) begin
                    @(negedge clk);
                    #3;
                    fire = bus.s_axis_tready;
                    waitCycles++;
                end
                if (!fire) begin
                    checkOutput("beatTimeout", 64'(p), 64'(tNumPkts));
                    bus.s_axis_tvalid = 1'b0;
                    return;
                end
                @(negedge clk);
            end
        end
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic checkHeader(input int h);
        bit first, last;
        first = (h == 0);
        last  = (h == tNumPkts - 1);
        checkOutput("opcode", 64'(bus.m_hdr_opcode), 64'(expOpcode(tSend, tImm, first, last)));
        checkOutput("psn", 64'(bus.m_hdr_psn), 64'(modelPsn));
        checkOutput("destQp", 64'(bus.m_hdr_dest_qp), 64'(tQp));
        checkOutput("ackReq", 64'(bus.m_hdr_ack_req), 64'(last));
        checkOutput("rethPresent", 64'(bus.m_hdr_reth_present), 64'(!tSend && first));
        if (!tSend && first) begin
            checkOutput("rethAddr", bus.m_hdr_reth_addr, tAddr);
            checkOutput("rethLength", 64'(bus.m_hdr_reth_length), 64'(tDmaLen));
        end
        checkOutput("immPresent", 64'(bus.m_hdr_immdt_present), 64'(last && tImm));
        if (last && tImm) checkOutput("immdt", 64'(bus.m_hdr_immdt), 64'(tImmData));
        checkOutput("payloadLength", 64'(bus.m_hdr_payload_length), 64'(tLen[h]));
        checkOutput("hdrBad", 64'(bus.m_hdr_bad), 64'(tBad[h]));
    endtask

    task automatic monitorHeaders();
        int          h, cycles, validSeen;
        bit          prevStall;
        logic [200:0] prevVec, curVec;
        h = 0; cycles = 0; validSeen = 0; prevStall = 1'b0; prevVec = '0;
        while (h < tNumPkts && cycles < BUDGET) begin
            @(negedge clk);
            bus.m_hdr_ready = (validSeen >= tHold) && ($urandom_range(0, 3) != 0);
            #3;
            cycles++;
            curVec = {bus.m_hdr_opcode, bus.m_hdr_psn, bus.m_hdr_dest_qp, bus.m_hdr_ack_req,
                      bus.m_hdr_reth_present, bus.m_hdr_reth_addr, bus.m_hdr_reth_length,
                      bus.m_hdr_immdt_present, bus.m_hdr_immdt, bus.m_hdr_payload_length, bus.m_hdr_bad};
            if (bus.m_hdr_valid) begin
                validSeen++;
                checkOutput("hdrBlocksPayload", 64'(bus.s_axis_tready), 64'd0);
                if (prevStall) checkOutput("hdrStable", 64'(curVec == prevVec), 64'd1);
                if (bus.m_hdr_ready) begin
                    checkHeader(h);
                    h++;
                    hdrAccepted++;
                    modelPsn = modelPsn + 24'd1;
                    validSeen = 0;
                end
            end
            prevStall = bus.m_hdr_valid && !bus.m_hdr_ready;
            prevVec   = curVec;
        end
        if (h < tNumPkts) checkOutput("hdrTimeout", 64'(h), 64'(tNumPkts));
        @(negedge clk);
        bus.m_hdr_ready = 1'b0;
    endtask

    task automatic monitorPayload();
        int    total, seen, pkt, cycles;
        bit    toggle;
        beat_t bt;
        total = 0; seen = 0; pkt = 0; cycles = 0; toggle = 1'b0;
        for (int p = 0; p < tNumPkts; p++) total += (tLen[p] + 7) / 8;
        while (seen < total && cycles < BUDGET) begin
            @(negedge clk);
            case (tReadyMode)
                0:       bus.m_axis_tready = 1'b1;
                1:       bus.m_axis_tready = 1'($urandom_range(0, 1));
                default: begin toggle = !toggle; bus.m_axis_tready = toggle; end
            endcase
            #3;
            cycles++;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                checkOutput("beatAfterHdr", 64'(hdrAccepted > pkt), 64'd1);
                if (expBeats.size() == 0) begin
                    checkOutput("extraBeat", 64'd1, 64'd0);
                end else begin
                    bt = expBeats.pop_front();
                    checkOutput("tdata", bus.m_axis_tdata, bt.data);
                    checkOutput("tkeep", 64'(bus.m_axis_tkeep), 64'(bt.keep));
                    checkOutput("tlast", 64'(bus.m_axis_tlast), 64'(bt.last));
                    checkOutput("tuser", 64'(bus.m_axis_tuser), 64'(bt.bad));
                end
                if (bus.m_axis_tlast) pkt++;
                seen++;
            end
        end
        if (seen < total) checkOutput("payloadTimeout", 64'(seen), 64'(total));
        @(negedge clk);
        bus.m_axis_tready = 1'b0;
    endtask

    task automatic runTransfer(input int dmaOverride);
        int sum, snap, expErr;
        sum = 0;
        for (int p = 0; p < tNumPkts; p++) sum += tLen[p];
        tDmaLen     = (dmaOverride < 0) ? 32'(sum) : 32'(dmaOverride);
        hdrAccepted = 0;
        expBeats.delete();
        snap = errPulses;
        fork
            applyStimulus();
            monitorHeaders();
            monitorPayload();
        join
        repeat (3) @(negedge clk);
        checkOutput("leftoverBeats", 64'(expBeats.size()), 64'd0);
`ifdef ROCE_TX_SEQ_LEN_CHECK_EN
        expErr = (32'(sum) != tDmaLen) ? 1 : 0;
`else
        expErr = 0;
`endif
        checkOutput("errLenMismatch", 64'(errPulses - snap), 64'(expErr));
    endtask

    initial begin
        int  waitCycles;
        bit  fire;
        bus.s_wr_req_valid          = 1'b0;
        bus.s_wr_req_loc_qp         = '0;
        bus.s_wr_req_dma_length     = '0;
        bus.s_wr_req_addr_offset    = '0;
        bus.s_wr_req_is_immediate   = 1'b0;
        bus.s_wr_req_immediate_data = '0;
        bus.s_wr_req_tx_type        = 1'b0;
        bus.s_axis_tdata            = '0;
        bus.s_axis_tkeep            = '0;
        bus.s_axis_tvalid           = 1'b0;
        bus.s_axis_tlast            = 1'b0;
        bus.s_axis_tuser            = '0;
        bus.m_hdr_ready             = 1'b0;
        bus.m_axis_tready           = 1'b0;

        repeat (2) @(negedge clk);
        #3;
        checkOutput("rstReqReady", 64'(bus.s_wr_req_ready), 64'd0);
        checkOutput("rstHdrValid", 64'(bus.m_hdr_valid), 64'd0);
        checkOutput("rstOpcode", 64'(bus.m_hdr_opcode), 64'd0);
        checkOutput("rstPsn", 64'(bus.m_hdr_psn), 64'd0);
        checkOutput("rstRethAddr", bus.m_hdr_reth_addr, 64'd0);
        checkOutput("rstSTready", 64'(bus.s_axis_tready), 64'd0);
        checkOutput("rstMTvalid", 64'(bus.m_axis_tvalid), 64'd0);
        checkOutput("rstErr", 64'(errLenMismatch), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #3;
        checkOutput("readyAfterReset", 64'(bus.s_wr_req_ready), 64'd1);

        // WRITE only packet with PSN preloaded
        setPsn(24'd5);
        setupTransfer(1'b0, 1'b0, 32'd0, 1, 0, 0);
        tLen[0] = 256;
        runTransfer(-1);
        checkOutput("psnAfterOnly", 64'(modelPsn), 64'd6);

        // WRITE with immediate across three packets
        setupTransfer(1'b0, 1'b1, 32'hDEADBEEF, 3, 0, 1);
        tLen[0] = 1024; tLen[1] = 1024; tLen[2] = 100;
        runTransfer(-1);

        // SEND, two packets
        setupTransfer(1'b1, 1'b0, 32'd0, 2, 0, 0);
        tLen[0] = 256; tLen[1] = 40;
        runTransfer(-1);

        // PSN wraps from 0xFFFFFF to 0
        setPsn(24'hFFFFFF);
        setupTransfer(1'b0, 1'b0, 32'd0, 2, 0, 1);
        tLen[0] = 128; tLen[1] = 64;
        runTransfer(-1);

        // Header held off for 10 cycles, toggling payload ready
        setupTransfer(1'b0, 1'b0, 32'd0, 2, 10, 2);
        tLen[0] = 64; tLen[1] = 24;
        runTransfer(-1);

        // Length mismatch: 2048 requested, 2000 delivered
        setupTransfer(1'b0, 1'b0, 32'd0, 2, 0, 0);
        tLen[0] = 1024; tLen[1] = 976;
        runTransfer(2048);

        for (int r = 0; r < 8; r++) begin
            int pmtu;
            if ($urandom_range(0, 2) == 0) setPsn(24'($urandom));
            setupTransfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                          $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 2));
            pmtu = 64 << $urandom_range(0, 2);
            for (int p = 0; p < tNumPkts; p++) begin
                tLen[p] = (p == tNumPkts - 1) ? $urandom_range(1, pmtu) : pmtu;
                tBad[p] = ($urandom_range(0, 7) == 0);
            end
            runTransfer(-1);
        end

        // Reset in the middle of a packet aborts it
        @(negedge clk);
        bus.s_wr_req_valid   = 1'b1;
        bus.s_wr_req_tx_type = 1'b0;
        #3;
        checkOutput("abortReqReady", 64'(bus.s_wr_req_ready), 64'd1);
        @(negedge clk);
        bus.s_wr_req_valid = 1'b0;
        bus.s_axis_tvalid  = 1'b1;
        bus.s_axis_tlast   = 1'b0;
        bus.s_axis_tkeep   = 8'hFF;
        bus.s_axis_tuser   = {13'd64, 1'b1, 1'b0};
        bus.m_hdr_ready    = 1'b1;
        bus.m_axis_tready  = 1'b0;
        waitCycles = 0;
        fire = 1'b0;
        while (!fire && waitCycles < 20) begin
            @(negedge clk);
            #3;
            fire = bus.m_hdr_valid;
            waitCycles++;
        end
        checkOutput("abortHdrSeen", 64'(fire), 64'd1);
        @(negedge clk);
        bus.m_hdr_ready = 1'b0;
        #3;
        checkOutput("abortPassthrough", 64'(bus.m_axis_tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abortMTvalid", 64'(bus.m_axis_tvalid), 64'd0);
        checkOutput("abortSTready", 64'(bus.s_axis_tready), 64'd0);
        checkOutput("abortHdrValid", 64'(bus.m_hdr_valid), 64'd0);
        checkOutput("abortReqReady0", 64'(bus.s_wr_req_ready), 64'd0);
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
        rst_n = 1'b1;
        modelPsn = 24'd0;
        @(negedge clk);

        // Fresh transfer after the abort starts from PSN 0
        setupTransfer(1'b1, 1'b1, 32'h12345678, 1, 0, 0);
        tLen[0] = 33;
        runTransfer(-1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
